register_file_scoreboard: RTL

- Parametrised successor to the 32 x 64 register file: configurable width and depth, optional hardwired zero register, two combinational read ports and one synchronous write port.
- Adds same-cycle write-to-read forwarding and a per-register busy scoreboard.
- The scoreboard lets the datapath reserve a destination register for a multi-cycle producer (e.g. a load) and detect read-after-write hazards on either read port.
- Sits between decode/issue and the execute stage of the datapath.

---
 rtl/register_file_scoreboard.sv | 123 ++++++++++++
 1 files changed

// File: rtl/register_file_scoreboard.sv
// Register file with two combinational read ports, one synchronous write port,
// same-cycle write forwarding and a per-register busy scoreboard used to track
// outstanding multi-cycle producers (read-after-write hazard detection).
module register_file_scoreboard #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] select_a,
  input  logic [ADDR_WIDTH-1:0] select_b,
  output logic [WIDTH-1:0]      out_a,
  output logic [WIDTH-1:0]      out_b,
  output logic                  busy_a,
  output logic                  busy_b,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserve_address,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CntW-1:0]  busy_count_q, busy_count_d;
  logic             write_ok, reserve_ok;
  logic             fwd_a, fwd_b;

  // True when idx addresses the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == ZeroIdx);
  endfunction

  // Writes and reservations aimed at the zero register are dropped here so
  // the storage, busy bits and population count never see them.
  assign write_ok   = write && !is_zero(address);
  assign reserve_ok = reserve && !is_zero(reserve_address);

  // Forwarding matches; the zero-register override is applied later.
  assign fwd_a = (BYPASS != 0) && write && (address == select_a);
  assign fwd_b = (BYPASS != 0) && write && (address == select_b);

  // Next busy vector: a write retires a reservation, a reservation in the
  // same edge to the same register wins because it is applied last.
  always_comb begin
    busy_d = busy_q;
    if (write_ok) begin
      busy_d[address] = 1'b0;
    end
    if (reserve_ok) begin
      busy_d[reserve_address] = 1'b1;
    end
  end

  // Population count of the next busy vector so the count tracks the bits.
  always_comb begin
    busy_count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + CntW'(busy_d[i]);
    end
  end

  // Register storage; zero register is never written so it stays at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_ok) begin
      mem_q[address] <= data_in;
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Read port A: stored value, overridden by forwarding, then zero register,
  // and forced quiet while reset is held so no pending write leaks through.
  always_comb begin
    out_a  = mem_q[select_a];
    busy_a = busy_q[select_a];
    if (fwd_a) begin
      out_a  = data_in;
      busy_a = 1'b0;
    end
    if (is_zero(select_a) || reset) begin
      out_a  = '0;
      busy_a = 1'b0;
    end
  end

  // Read port B: identical to port A, fully independent.
  always_comb begin
    out_b  = mem_q[select_b];
    busy_b = busy_q[select_b];
    if (fwd_b) begin
      out_b  = data_in;
      busy_b = 1'b0;
    end
    if (is_zero(select_b) || reset) begin
      out_b  = '0;
      busy_b = 1'b0;
    end
  end

  assign busy_count = busy_count_q;

endmodule
